// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-master SRAM arbiter: FSM encoding,
// grant identifiers and the default wait-state count.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEF_WAIT_STATES = 1;

    // The round-robin winner on a tie is always the master that was not
    // served last.
    function automatic logic other_master(input logic grant_id);
        return ~grant_id;
    endfunction

endpackage

// File: rtl/sram_wb_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. A lone requester always wins;
// on a tie the master that was not granted last wins.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    // Select the winner from the current requests and the previous grant
    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_grant = other_master(i_last_grant);
        end else if (i_req1) begin
            o_grant = M1;
        end else begin
            o_grant = M0;
        end
    end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Shares one asynchronous SRAM between two Wishbone masters. A granted
// request is latched, held on the SRAM pins for WAIT_STATES+1 clocks,
// and answered with a one-clock ack to the granted master. All SRAM pins
// and acks come straight from flops.
module sram_wb_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = DEF_WAIT_STATES
)(
    input  logic              i_wb_clk,
    input  logic              i_wb_rst,
    input  logic              i_wb0_cyc,
    input  logic              i_wb0_stb,
    input  logic              i_wb0_we,
    input  logic [ADDR_W-1:0] i_wb0_addr,
    input  logic [DATA_W-1:0] i_wb0_dat,
    output logic [DATA_W-1:0] o_wb0_dat,
    output logic              o_wb0_ack,
    input  logic              i_wb1_cyc,
    input  logic              i_wb1_stb,
    input  logic              i_wb1_we,
    input  logic [ADDR_W-1:0] i_wb1_addr,
    input  logic [DATA_W-1:0] i_wb1_dat,
    output logic [DATA_W-1:0] o_wb1_dat,
    output logic              o_wb1_ack,
    input  logic [DATA_W-1:0] i_ram_dat,
    output logic [DATA_W-1:0] o_ram_dat,
    output logic              o_ram_dat_oe,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_ce,
    output logic              o_ram_oe,
    output logic              o_ram_we
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    arb_state_t        r_state;
    arb_state_t        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdat;
    logic              r_we;
    logic              r_gnt;
    logic              r_last_grant;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_rdat0;
    logic [DATA_W-1:0] r_rdat1;

    logic              r_ram_ce;
    logic              r_ram_oe;
    logic              r_ram_we;
    logic              r_ram_dat_oe;
    logic              r_ack0;
    logic              r_ack1;

    logic              w_req0;
    logic              w_req1;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_take;
    logic              w_capture;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_dat;
    logic              w_sel_we;
    logic              w_nxt_we;
    logic              w_nxt_gnt;

    logic              w_nxt_ce;
    logic              w_nxt_oe;
    logic              w_nxt_wen;
    logic              w_nxt_dat_oe;
    logic              w_nxt_ack0;
    logic              w_nxt_ack1;

    assign w_req0 = i_wb0_cyc & i_wb0_stb;
    assign w_req1 = i_wb1_cyc & i_wb1_stb;

    rr_arb2 u_rr_arb2 (
        .i_req0       (w_req0),
        .i_req1       (w_req1),
        .i_last_grant (r_last_grant),
        .o_valid      (w_grant_valid),
        .o_grant      (w_grant_id)
    );

    assign w_take    = (r_state == ST_IDLE) & w_grant_valid;
    assign w_capture = (r_state == ST_ACCESS) & (r_cnt == 4'd0) & ~r_we;

    // Route the winning master's request fields and form the values the
    // latched request will hold after this edge
    always_comb begin
        if (w_grant_id == M1) begin
            w_sel_addr = i_wb1_addr;
            w_sel_dat  = i_wb1_dat;
            w_sel_we   = i_wb1_we;
        end else begin
            w_sel_addr = i_wb0_addr;
            w_sel_dat  = i_wb0_dat;
            w_sel_we   = i_wb0_we;
        end
        if (w_take) begin
            w_nxt_we  = w_sel_we;
            w_nxt_gnt = w_grant_id;
        end else begin
            w_nxt_we  = r_we;
            w_nxt_gnt = r_gnt;
        end
    end

    // FSM state register
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_ACK;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACK:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered pins, decoded from
    // the state being entered so pins and state change on the same edge.
    // Ack looks at cyc at the end of the access; a dropped cyc loses it.
    always_comb begin
        w_nxt_ce     = 1'b0;
        w_nxt_oe     = 1'b0;
        w_nxt_wen    = 1'b0;
        w_nxt_dat_oe = 1'b0;
        w_nxt_ack0   = 1'b0;
        w_nxt_ack1   = 1'b0;
        case (w_next_state)
            ST_ACCESS: begin
                w_nxt_ce     = 1'b1;
                w_nxt_oe     = ~w_nxt_we;
                w_nxt_wen    = w_nxt_we;
                w_nxt_dat_oe = w_nxt_we;
            end
            ST_ACK: begin
                w_nxt_ack0 = (w_nxt_gnt == M0) & i_wb0_cyc;
                w_nxt_ack1 = (w_nxt_gnt == M1) & i_wb1_cyc;
            end
            ST_IDLE: begin
                w_nxt_ce = 1'b0;
            end
            default: begin
                w_nxt_ce = 1'b0;
            end
        endcase
    end

    // Output pin registers; reset clears every control in the same edge
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_ram_ce     <= 1'b0;
            r_ram_oe     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_dat_oe <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_ram_ce     <= w_nxt_ce;
            r_ram_oe     <= w_nxt_oe;
            r_ram_we     <= w_nxt_wen;
            r_ram_dat_oe <= w_nxt_dat_oe;
            r_ack0       <= w_nxt_ack0;
            r_ack1       <= w_nxt_ack1;
        end
    end

    // Request latch, wait counter and round-robin history; master inputs
    // are only looked at on the grant edge
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_addr       <= '0;
            r_wdat       <= '0;
            r_we         <= 1'b0;
            r_gnt        <= M0;
            r_last_grant <= M1;
            r_cnt        <= 4'd0;
        end else if (w_take) begin
            r_addr       <= w_sel_addr;
            r_wdat       <= w_sel_dat;
            r_we         <= w_sel_we;
            r_gnt        <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_cnt        <= WS_INIT;
        end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Per-master read data, updated only by that master's completed read
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_rdat0 <= '0;
            r_rdat1 <= '0;
        end else if (w_capture) begin
            if (r_gnt == M1) begin
                r_rdat1 <= i_ram_dat;
            end else begin
                r_rdat0 <= i_ram_dat;
            end
        end else begin
            r_rdat0 <= r_rdat0;
        end
    end

    assign o_ram_addr   = r_addr;
    assign o_ram_dat    = r_wdat;
    assign o_ram_ce     = r_ram_ce;
    assign o_ram_oe     = r_ram_oe;
    assign o_ram_we     = r_ram_we;
    assign o_ram_dat_oe = r_ram_dat_oe;
    assign o_wb0_dat    = r_rdat0;
    assign o_wb1_dat    = r_rdat1;
    assign o_wb0_ack    = r_ack0;
    assign o_wb1_ack    = r_ack1;

endmodule
